// File: rtl/eth_sched_pkg.sv
// Shared state encoding and counter widths for the Ethernet TX payload scheduler.
package eth_sched_pkg;

  localparam int BYTE_CNT_W  = 13;
  localparam int GAP_CNT_W   = 8;
  localparam int FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    STREAM = 2'd2,
    GAP    = 2'd3
  } sched_state_t;

endpackage

// File: rtl/eth_tx_scheduler.sv
// Pulls interleaved hi/lo sample bytes from the two sample FIFOs into the GMII
// frame builder, requests a frame slot per frame and paces frames with a gap.
module eth_tx_scheduler
  import eth_sched_pkg::*;
#(
  parameter int PAYLOAD_PAIRS = 512,
  parameter int IFG_CYCLES    = 12
) (
  input  logic                   GTXC,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   afull_flag1,
  input  logic                   afull_flag2,
  input  logic                   empty_flag1,
  input  logic                   empty_flag2,
  output logic                   rden_fifo1,
  output logic                   rden_fifo2,
  input  logic [7:0]             rddata_fifo1,
  input  logic [7:0]             rddata_fifo2,
  output logic                   tx_req,
  input  logic                   tx_ack,
  output logic [7:0]             pld_data,
  output logic                   pld_valid,
  output logic                   pld_last,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   underrun
);

  localparam logic [BYTE_CNT_W-1:0] LAST_IDX = BYTE_CNT_W'(2 * PAYLOAD_PAIRS - 1);
  localparam logic [GAP_CNT_W-1:0]  GAP_LAST = GAP_CNT_W'(IFG_CYCLES - 1);

  sched_state_t           state_r;
  sched_state_t           state_s;
  logic [BYTE_CNT_W-1:0]  byte_idx_r;
  logic [GAP_CNT_W-1:0]   gap_cnt_r;
  logic                   last_idx_s;
  logic                   rden1_s;
  logic                   rden2_s;
  logic                   sel_r;
  logic                   rd_ok_r;
  logic                   tx_req_r;
  logic                   pld_valid_r;
  logic                   pld_last_r;
  logic                   underrun_r;
  logic [FRAME_CNT_W-1:0] frame_cnt_r;
  logic [7:0]             pld_data_s;

  assign last_idx_s = (byte_idx_r == LAST_IDX);

  // State register.
  always_ff @(posedge GTXC) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: start condition, builder handshake, payload end and gap expiry.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable && afull_flag1 && afull_flag2) state_s = REQ;
        else                                      state_s = IDLE;
      end
      REQ: begin
        if (tx_ack) state_s = STREAM;
        else        state_s = REQ;
      end
      STREAM: begin
        if (last_idx_s) state_s = GAP;
        else            state_s = STREAM;
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) state_s = IDLE;
        else                       state_s = GAP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Byte index and gap counter; each rests at zero outside its own state.
  always_ff @(posedge GTXC) begin
    if (rst) begin
      byte_idx_r <= '0;
      gap_cnt_r  <= '0;
    end else begin
      if (state_r == STREAM) byte_idx_r <= byte_idx_r + BYTE_CNT_W'(1);
      else                   byte_idx_r <= '0;
      if (state_r == GAP) gap_cnt_r <= gap_cnt_r + GAP_CNT_W'(1);
      else                gap_cnt_r <= '0;
    end
  end

  // Read strobes: even index reads fifo1, odd index reads fifo2; an empty FIFO is skipped.
  always_comb begin
    rden1_s = 1'b0;
    rden2_s = 1'b0;
    if (state_r == STREAM) begin
      if (byte_idx_r[0]) rden2_s = ~empty_flag2;
      else               rden1_s = ~empty_flag1;
    end else begin
      rden1_s = 1'b0;
      rden2_s = 1'b0;
    end
  end

  // Registered handshake, framing, counter and status outputs.
  always_ff @(posedge GTXC) begin
    if (rst) begin
      tx_req_r    <= 1'b0;
      pld_valid_r <= 1'b0;
      pld_last_r  <= 1'b0;
      sel_r       <= 1'b0;
      rd_ok_r     <= 1'b0;
      frame_cnt_r <= '0;
      underrun_r  <= 1'b0;
    end else begin
      tx_req_r    <= (state_s == REQ);
      pld_valid_r <= (state_r == STREAM);
      pld_last_r  <= (state_r == STREAM) && last_idx_s;
      sel_r       <= byte_idx_r[0];
      rd_ok_r     <= rden1_s | rden2_s;
      if ((state_r == STREAM) && last_idx_s) frame_cnt_r <= frame_cnt_r + FRAME_CNT_W'(1);
      else                                   frame_cnt_r <= frame_cnt_r;
      if ((state_r == STREAM) && !(rden1_s || rden2_s)) underrun_r <= 1'b1;
      else                                              underrun_r <= underrun_r;
    end
  end

  // Payload mux: FIFO data lands one cycle after its strobe; a skipped read sends zero.
  always_comb begin
    pld_data_s = 8'h00;
    if (pld_valid_r && rd_ok_r) begin
      if (sel_r) pld_data_s = rddata_fifo2;
      else       pld_data_s = rddata_fifo1;
    end else begin
      pld_data_s = 8'h00;
    end
  end

  assign rden_fifo1 = rden1_s;
  assign rden_fifo2 = rden2_s;
  assign tx_req     = tx_req_r;
  assign pld_data   = pld_data_s;
  assign pld_valid  = pld_valid_r;
  assign pld_last   = pld_last_r;
  assign frame_cnt  = frame_cnt_r;
  assign underrun   = underrun_r;

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Self-checking bench for eth_tx_scheduler: FIFO models plus a frame-level
// reference built from request/ack timing windows and queued payload bytes.
module tb_eth_tx_scheduler;

  localparam int PP  = 4;
  localparam int IFG = 3;
  localparam int NB  = 2 * PP;

  logic        GTXC = 1'b0;
  logic        rst, enable, afull_flag1, afull_flag2, empty_flag1, empty_flag2;
  logic        rden_fifo1, rden_fifo2, tx_req, tx_ack, pld_valid, pld_last, underrun;
  logic [7:0]  rddata_fifo1, rddata_fifo2, pld_data;
  logic [15:0] frame_cnt;

  eth_tx_scheduler #(.PAYLOAD_PAIRS(PP), .IFG_CYCLES(IFG)) dut (
    .GTXC(GTXC), .rst(rst), .enable(enable),
    .afull_flag1(afull_flag1), .afull_flag2(afull_flag2),
    .empty_flag1(empty_flag1), .empty_flag2(empty_flag2),
    .rden_fifo1(rden_fifo1), .rden_fifo2(rden_fifo2),
    .rddata_fifo1(rddata_fifo1), .rddata_fifo2(rddata_fifo2),
    .tx_req(tx_req), .tx_ack(tx_ack),
    .pld_data(pld_data), .pld_valid(pld_valid), .pld_last(pld_last),
    .frame_cnt(frame_cnt), .underrun(underrun)
  );

  always #4 GTXC = ~GTXC;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [7:0]  fifo1_q[$];
  logic [7:0]  fifo2_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  obs_q[$];
  logic [NB-1:0] sup_mask = '0;
  logic [NB-1:0] next_mask = '0;
  bit          use_next_mask = 1'b0;
  bit          random_mask_en = 1'b0;
  int          ack_cyc = -1;
  int          idle_from = 0;
  bit          req_exp = 1'b0;
  logic [15:0] exp_frames = 16'h0000;
  bit          exp_under = 1'b0;
  bit          rd1_seen = 1'b0;
  bit          rd2_seen = 1'b0;
  int          last_valid = -1;
  int          req_fall = -1;
  bit          prev_req = 1'b0;
  logic [7:0]  frame1_ref [NB] = '{8'h01, 8'h81, 8'h02, 8'h82, 8'h03, 8'h83, 8'h04, 8'h84};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Compare this cycle's outputs with the frame-level reference, then advance it.
  task automatic sample();
    int k, r, p1, p2;
    bit in_win, rd_win, last_cyc;
    logic [7:0] exp_byte;
    k        = cyc - ack_cyc - 2;
    r        = k + 1;
    in_win   = (ack_cyc >= 0) && (k >= 0) && (k < NB);
    rd_win   = (ack_cyc >= 0) && (r >= 0) && (r < NB);
    last_cyc = in_win && (k == NB - 1);
    exp_byte = 8'h00;
    if (in_win) exp_byte = exp_q[k];
    if (last_cyc) exp_frames = exp_frames + 16'd1;
    if (in_win && sup_mask[k]) exp_under = 1'b1;

    check("tx_req", tx_req, req_exp);
    check("pld_valid", pld_valid, in_win);
    check("pld_last", pld_last, last_cyc);
    check("pld_data", pld_data, exp_byte);
    check("frame_cnt", frame_cnt, exp_frames);
    check("underrun", underrun, exp_under);
    check("rden_exclusive", rden_fifo1 & rden_fifo2, 1'b0);
    if (rd_win) begin
      check("rden_fifo1", rden_fifo1, (r % 2 == 0) && !empty_flag1);
      check("rden_fifo2", rden_fifo2, (r % 2 == 1) && !empty_flag2);
    end else begin
      check("rden_idle", {rden_fifo1, rden_fifo2}, 2'b00);
    end
    if (pld_valid) begin
      if (last_valid >= 0 && cyc - last_valid > 1)
        check("frame_gap", (cyc - last_valid - 1) >= IFG + 2, 1'b1);
      last_valid = cyc;
      obs_q.push_back(pld_data);
    end
    if (tx_req && !prev_req && req_fall >= 0)
      check("req_low_gap", (cyc - req_fall) >= IFG + 2, 1'b1);
    prev_req = tx_req;
    rd1_seen = rden_fifo1;
    rd2_seen = rden_fifo2;

    if (rst) begin
      req_exp = 1'b0; ack_cyc = -1; exp_frames = 16'h0000; exp_under = 1'b0;
      idle_from = cyc + 1; last_valid = -1; req_fall = -1;
    end else if (req_exp) begin
      if (tx_ack) begin
        req_exp   = 1'b0;
        ack_cyc   = cyc;
        req_fall  = cyc + 1;
        idle_from = cyc + 1 + NB + IFG;
        if (use_next_mask) sup_mask = next_mask;
        else if (random_mask_en && $urandom_range(0, 3) == 0) sup_mask = NB'($urandom);
        else sup_mask = '0;
        use_next_mask = 1'b0;
        exp_q.delete();
        p1 = 0; p2 = 0;
        for (int i = 0; i < NB; i++) begin
          if (sup_mask[i])     exp_q.push_back(8'h00);
          else if (i % 2 == 0) begin exp_q.push_back(fifo1_q[p1]); p1++; end
          else                 begin exp_q.push_back(fifo2_q[p2]); p2++; end
        end
      end
    end else if (cyc >= idle_from && enable && afull_flag1 && afull_flag2) begin
      req_exp = 1'b1;
    end
  endtask

  // FIFO model: pop on last cycle's strobe, keep stocked, drive empty flags for this cycle.
  task automatic post();
    int r;
    if (rd1_seen) rddata_fifo1 = fifo1_q.pop_front();
    if (rd2_seen) rddata_fifo2 = fifo2_q.pop_front();
    while (fifo1_q.size() < 16) fifo1_q.push_back(8'($urandom));
    while (fifo2_q.size() < 16) fifo2_q.push_back(8'($urandom));
    r = cyc - ack_cyc - 1;
    empty_flag1 = 1'($urandom_range(0, 1));
    empty_flag2 = 1'($urandom_range(0, 1));
    if (ack_cyc >= 0 && r >= 0 && r < NB) begin
      if (r % 2 == 0) empty_flag1 = sup_mask[r];
      else            empty_flag2 = sup_mask[r];
    end
  endtask

  task automatic tick();
    @(negedge GTXC);
    sample();
    @(posedge GTXC);
    #1;
    cyc++;
    post();
  endtask

  // Wait for a request, ack after ack_delay cycles, then run through payload and gap.
  task automatic do_frame(input int ack_delay, input int drop_en_byte, input int rst_byte);
    int n;
    n = 0;
    while (!tx_req && n < 300) begin tick(); n++; end
    check("req_timeout", tx_req, 1'b1);
    repeat (ack_delay) tick();
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    for (int i = 1; i <= NB + IFG + 1; i++) begin
      if (drop_en_byte > 0 && i == drop_en_byte + 1) enable = 1'b0;
      rst = (rst_byte > 0 && i == rst_byte + 1);
      if (rst_byte > 0 && i == rst_byte + 2) begin
        check("rst_pld_valid", pld_valid, 1'b0);
        check("rst_pld_last", pld_last, 1'b0);
        check("rst_frame_cnt", frame_cnt, 16'h0000);
        check("rst_rden", {rden_fifo1, rden_fifo2}, 2'b00);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; afull_flag1 = 1'b0; afull_flag2 = 1'b0;
    empty_flag1 = 1'b0; empty_flag2 = 1'b0; tx_ack = 1'b0;
    rddata_fifo1 = 8'h00; rddata_fifo2 = 8'h00;
    for (int i = 1; i <= NB / 2; i++) begin
      fifo1_q.push_back(8'(i));
      fifo2_q.push_back(8'(8'h80 + i));
    end
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Directed frame with known payload, ack two cycles after the request.
    enable = 1'b1; afull_flag1 = 1'b1; afull_flag2 = 1'b1;
    obs_q.delete();
    do_frame(2, 0, 0);
    enable = 1'b0;
    check("frame1_len", obs_q.size(), NB);
    for (int i = 0; i < NB && i < obs_q.size(); i++) check("frame1_byte", obs_q[i], frame1_ref[i]);
    check("frame1_cnt", frame_cnt, 16'd1);

    // Builder withholds the grant for 100 cycles.
    enable = 1'b1;
    do_frame(100, 0, 0);

    // Suppressed fifo2 read at index 3.
    next_mask = NB'(8'b0000_1000);
    use_next_mask = 1'b1;
    do_frame(1, 0, 0);
    check("underrun_set", underrun, 1'b1);

    // Enable drops at the third payload byte.
    do_frame(0, 3, 0);
    repeat (20) tick();
    check("no_req_after_disable", tx_req, 1'b0);

    // Reset at the fifth payload byte, then a normal frame.
    enable = 1'b1;
    do_frame(0, 0, 5);
    check("underrun_cleared", underrun, 1'b0);
    do_frame(3, 0, 0);
    check("post_rst_cnt", frame_cnt, 16'd1);

    // Frame counter wrap.
    enable = 1'b0;
    repeat (25) tick();
    force dut.frame_cnt_r = 16'hFFFE;
    exp_frames = 16'hFFFE;
    #1;
    release dut.frame_cnt_r;
    enable = 1'b1;
    do_frame(1, 0, 0);
    check("cnt_ffff", frame_cnt, 16'hFFFF);
    do_frame(1, 0, 0);
    check("cnt_wrap", frame_cnt, 16'h0000);

    // Randomized traffic against the reference.
    random_mask_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      enable      = ($urandom_range(0, 9) != 0);
      afull_flag1 = ($urandom_range(0, 7) != 0);
      afull_flag2 = ($urandom_range(0, 7) != 0);
      tx_ack      = tx_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      rst         = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0; tx_ack = 1'b0; enable = 1'b0;
    repeat (30) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
